// File: rtl/buscaminas_pkg.sv
// Shared types and board geometry helpers for the Buscaminas reveal sequencer.
package buscaminas_pkg;

  localparam int DEF_N_ROWS  = 8;
  localparam int DEF_N_COLS  = 8;
  localparam int DEF_N_CELLS = DEF_N_ROWS * DEF_N_COLS;
  localparam int DEF_IW      = $clog2(DEF_N_CELLS);

  typedef logic [DEF_IW-1:0] cell_idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_EXPAND,
    S_CHECK_WIN,
    S_WON,
    S_LOST
  } state_t;

  // Direction order: NW, N, NE, W, E, SW, S, SE
  localparam int DX [8] = '{-1,  0,  1, -1, 1, -1, 0, 1};
  localparam int DY [8] = '{-1, -1, -1,  0, 0,  1, 1, 1};

  // Linear index of the neighbour of idx in direction dir; valid drops to 0
  // when the neighbour falls off the board (no wrap between rows/columns).
  function automatic int neighbour_idx(input int idx, input logic [2:0] dir,
                                       output logic valid,
                                       input int n_rows, input int n_cols);
    int x, y, nx, ny;
    x  = idx % n_cols;
    y  = idx / n_cols;
    nx = x + DX[dir];
    ny = y + DY[dir];
    valid = (nx >= 0) && (nx < n_cols) && (ny >= 0) && (ny < n_rows);
    return valid ? (ny * n_cols + nx) : 0;
  endfunction

endpackage

// File: rtl/buscaminas_cell_fifo.sv
// Cell-index queue for the flood fill. Read data comes straight from the
// storage flops (head entry), so there is no push-to-read combinational path.
module buscaminas_cell_fifo #(
  parameter int DEPTH = 64,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          full, do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (PW+1)'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage write; contents need no reset because count_q gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/buscaminas_reveal_ctrl.sv
// Buscaminas reveal sequencer: click handling, queue-based flood fill,
// win/lose detection and count-RAM write strobes.
// Optional cell flagging is enabled with `define BUSCAMINAS_FLAG_EN.
//
// state       | meaning
// ------------+--------------------------------------------------
// S_IDLE      | waiting for a click (click_ready=1)
// S_POP       | pop next queued cell, reveal it, emit its count
// S_EXPAND    | visit one neighbour of a zero cell per cycle
// S_CHECK_WIN | queue drained; compare revealed map with bombs
// S_WON       | terminal, win=1 until new_game
// S_LOST      | terminal, lose=1 until new_game
module buscaminas_reveal_ctrl
  import buscaminas_pkg::*;
#(
  parameter  int N_ROWS  = DEF_N_ROWS,
  parameter  int N_COLS  = DEF_N_COLS,
  localparam int N_CELLS = N_ROWS * N_COLS,
  localparam int IW      = $clog2(N_CELLS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_game,
  input  logic [N_CELLS-1:0] bombs_in,
  input  logic               click_valid,
  output logic               click_ready,
  input  logic [3:0]         click_x,
  input  logic [3:0]         click_y,
  output logic [N_CELLS-1:0] revealed,
  output logic               cnt_we,
  output logic [IW-1:0]      cnt_idx,
  output logic [3:0]         cnt_val,
  output logic               busy,
  output logic               done,
  output logic               win,
  output logic               lose
`ifdef BUSCAMINAS_FLAG_EN
  ,
  input  logic               flag_valid,
  input  logic [3:0]         flag_x,
  input  logic [3:0]         flag_y,
  output logic [N_CELLS-1:0] flagged
`endif
);

  state_t             state_q, state_d;
  logic [N_CELLS-1:0] bombs_q, bombs_d;
  logic [N_CELLS-1:0] revealed_q, revealed_d;
  logic [N_CELLS-1:0] queued_q, queued_d;
  logic [IW-1:0]      cur_q, cur_d;
  logic [2:0]         dir_q, dir_d;
  logic               done_q, done_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;

  logic [N_CELLS-1:0] flag_map;
  logic               fifo_push, fifo_pop, fifo_flush, fifo_empty;
  logic [IW-1:0]      fifo_push_data, pop_idx;
  logic               click_in_range;
  logic [IW-1:0]      click_idx;
  logic               nb_ok;
  logic [IW-1:0]      nb_idx;
  logic [3:0]         pop_cnt;
  logic               cnt_we_c, check_done;

  function automatic logic [IW-1:0] nb_of(input logic [IW-1:0] idx,
                                          input logic [2:0] dir,
                                          output logic ok);
    int n;
    n = neighbour_idx(int'(idx), dir, ok, N_ROWS, N_COLS);
    return IW'(n);
  endfunction

  function automatic logic [3:0] count_bombs(input logic [IW-1:0] idx,
                                             input logic [N_CELLS-1:0] map);
    logic [3:0]    c;
    logic          ok;
    logic [IW-1:0] n;
    c = '0;
    for (int d = 0; d < 8; d++) begin
      n = nb_of(idx, 3'(d), ok);
      if (ok && map[n]) c = c + 4'd1;
    end
    return c;
  endfunction

  assign click_in_range = (int'(click_x) < N_COLS) && (int'(click_y) < N_ROWS);
  assign click_idx      = IW'(int'(click_y) * N_COLS + int'(click_x));
  assign pop_cnt        = count_bombs(pop_idx, bombs_q);

  buscaminas_cell_fifo #(.DEPTH(N_CELLS), .W(IW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (pop_idx),
    .empty     (fifo_empty)
  );

`ifdef BUSCAMINAS_FLAG_EN
  logic [N_CELLS-1:0] flagged_q, flagged_d;
  logic               flag_in_range;
  logic [IW-1:0]      flag_idx;

  assign flag_in_range = (int'(flag_x) < N_COLS) && (int'(flag_y) < N_ROWS);
  assign flag_idx      = IW'(int'(flag_y) * N_COLS + int'(flag_x));
  assign flag_map      = flagged_q;
  assign flagged       = flagged_q;

  // Flag toggling is only honoured while idle and only on hidden cells.
  always_comb begin
    flagged_d = flagged_q;
    if (new_game) begin
      flagged_d = '0;
    end else if (state_q == S_IDLE && flag_valid && flag_in_range &&
                 !revealed_q[flag_idx]) begin
      flagged_d[flag_idx] = ~flagged_q[flag_idx];
    end
  end

  // Flag bitmap register.
  always_ff @(posedge clk) begin
    if (reset) flagged_q <= '0;
    else       flagged_q <= flagged_d;
  end
`else
  assign flag_map = '0;
`endif

  // Neighbour under inspection during expansion.
  always_comb begin
    nb_ok  = 1'b0;
    nb_idx = nb_of(cur_q, dir_q, nb_ok);
  end

  // Next-state and strobe logic; new_game overrides everything at the end.
  always_comb begin
    state_d        = state_q;
    bombs_d        = bombs_q;
    revealed_d     = revealed_q;
    queued_d       = queued_q;
    cur_d          = cur_q;
    dir_d          = dir_q;
    win_d          = win_q;
    lose_d         = lose_q;
    done_d         = 1'b0;
    fifo_push      = 1'b0;
    fifo_push_data = click_idx;
    fifo_pop       = 1'b0;
    fifo_flush     = 1'b0;
    cnt_we_c       = 1'b0;
    check_done     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (click_valid) begin
          if (!click_in_range || revealed_q[click_idx] || flag_map[click_idx]) begin
            done_d = 1'b1;
          end else if (bombs_q[click_idx]) begin
            state_d    = S_LOST;
            lose_d     = 1'b1;
            done_d     = 1'b1;
            revealed_d = revealed_q | bombs_q;
          end else begin
            fifo_push           = 1'b1;
            queued_d[click_idx] = 1'b1;
            state_d             = S_POP;
          end
        end
      end
      S_POP: begin
        if (fifo_empty) begin
          state_d = S_CHECK_WIN;
        end else begin
          fifo_pop            = 1'b1;
          cnt_we_c            = 1'b1;
          revealed_d[pop_idx] = 1'b1;
          cur_d               = pop_idx;
          if (pop_cnt == 4'd0) begin
            state_d = S_EXPAND;
            dir_d   = '0;
          end
        end
      end
      S_EXPAND: begin
        fifo_push_data = nb_idx;
        if (nb_ok && !queued_q[nb_idx] && !revealed_q[nb_idx] && !flag_map[nb_idx]) begin
          fifo_push        = 1'b1;
          queued_d[nb_idx] = 1'b1;
        end
        dir_d = dir_q + 3'd1;
        if (dir_q == 3'd7) state_d = S_POP;
      end
      S_CHECK_WIN: begin
        check_done = 1'b1;
        if (revealed_q == ~bombs_q) begin
          state_d = S_WON;
          win_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WON, S_LOST: begin
      end
      default: state_d = S_IDLE;
    endcase

    if (new_game) begin
      state_d    = S_IDLE;
      bombs_d    = bombs_in;
      revealed_d = '0;
      queued_d   = '0;
      cur_d      = '0;
      dir_d      = '0;
      win_d      = 1'b0;
      lose_d     = 1'b0;
      done_d     = 1'b0;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b1;
      cnt_we_c   = 1'b0;
      check_done = 1'b0;
    end
  end

  // State and bitmap registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bombs_q    <= '0;
      revealed_q <= '0;
      queued_q   <= '0;
      cur_q      <= '0;
      dir_q      <= '0;
      done_q     <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bombs_q    <= bombs_d;
      revealed_q <= revealed_d;
      queued_q   <= queued_d;
      cur_q      <= cur_d;
      dir_q      <= dir_d;
      done_q     <= done_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
    end
  end

  assign click_ready = (state_q == S_IDLE);
  assign busy        = (state_q == S_POP) || (state_q == S_EXPAND) || (state_q == S_CHECK_WIN);
  assign done        = done_q | check_done;
  assign cnt_we      = cnt_we_c;
  assign cnt_idx     = cnt_we_c ? pop_idx : '0;
  assign cnt_val     = cnt_we_c ? pop_cnt : '0;
  assign revealed    = revealed_q;
  assign win         = win_q;
  assign lose        = lose_q;

endmodule

// File: tb/tb_buscaminas_reveal_ctrl.sv
// Directed bench for buscaminas_reveal_ctrl: a table of click transactions
// plus hand-written sequences for latency, lose, mid-flood restart and flags.
module tb_buscaminas_reveal_ctrl;

  logic        clk = 1'b0;
  logic        reset, new_game;
  logic [63:0] bombs_in;
  logic        click_valid, click_ready;
  logic [3:0]  click_x, click_y;
  logic [63:0] revealed;
  logic        cnt_we;
  logic [5:0]  cnt_idx;
  logic [3:0]  cnt_val;
  logic        busy, done, win, lose;
`ifdef BUSCAMINAS_FLAG_EN
  logic        flag_valid;
  logic [3:0]  flag_x, flag_y;
  logic [63:0] flagged;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  logic [3:0] last_cnt [64];

  typedef struct {
    logic        ng;
    logic [63:0] bombs;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [63:0] exp_rev;
    logic        exp_win;
    logic        exp_lose;
    logic        exp_ready;
    int          exp_nwe;
  } vec_t;

  vec_t vecs [13];

  buscaminas_reveal_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .new_game    (new_game),
    .bombs_in    (bombs_in),
    .click_valid (click_valid),
    .click_ready (click_ready),
    .click_x     (click_x),
    .click_y     (click_y),
    .revealed    (revealed),
    .cnt_we      (cnt_we),
    .cnt_idx     (cnt_idx),
    .cnt_val     (cnt_val),
    .busy        (busy),
    .done        (done),
    .win         (win),
    .lose        (lose)
`ifdef BUSCAMINAS_FLAG_EN
    ,
    .flag_valid  (flag_valid),
    .flag_x      (flag_x),
    .flag_y      (flag_y),
    .flagged     (flagged)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic start_game(input logic [63:0] b);
    @(negedge clk);
    new_game = 1'b1;
    bombs_in = b;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  // Issues one click, counts cnt_we strobes until done, then settles one cycle.
  task automatic click_run(input logic [3:0] x, input logic [3:0] y,
                           output int nstrobe, output logic got_done);
    @(negedge clk);
    click_valid = 1'b1;
    click_x     = x;
    click_y     = y;
    @(negedge clk);
    click_valid = 1'b0;
    nstrobe     = 0;
    got_done    = 1'b0;
    for (int i = 0; i < 2000 && !got_done; i++) begin
      if (cnt_we) begin
        nstrobe++;
        last_cnt[cnt_idx] = cnt_val;
      end
      if (done) got_done = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    int   nwe;
    logic got;
    string nm;

    vecs[0]  = '{1'b1, 64'h1, 4'd7, 4'd7, ~64'h1, 1'b1, 1'b0, 1'b0, 63};
    vecs[1]  = '{1'b1, 64'h1, 4'd0, 4'd0, 64'h1, 1'b0, 1'b1, 1'b0, 0};
    vecs[2]  = '{1'b1, 64'h8100_0000_0000_0081, 4'd1, 4'd0, 64'h2, 1'b0, 1'b0, 1'b1, 1};
    vecs[3]  = '{1'b0, 64'h0, 4'd1, 4'd0, 64'h2, 1'b0, 1'b0, 1'b1, 0};
    vecs[4]  = '{1'b0, 64'h0, 4'd9, 4'd0, 64'h2, 1'b0, 1'b0, 1'b1, 0};
    vecs[5]  = '{1'b0, 64'h0, 4'd0, 4'd9, 64'h2, 1'b0, 1'b0, 1'b1, 0};
    vecs[6]  = '{1'b0, 64'h0, 4'd6, 4'd0, 64'h42, 1'b0, 1'b0, 1'b1, 1};
    vecs[7]  = '{1'b1, 64'h8100_0000_0000_0081, 4'd3, 4'd3, ~64'h8100_0000_0000_0081, 1'b1, 1'b0, 1'b0, 60};
    vecs[8]  = '{1'b1, 64'h0, 4'd4, 4'd4, ~64'h0, 1'b1, 1'b0, 1'b0, 64};
    vecs[9]  = '{1'b1, ~64'h1, 4'd0, 4'd0, 64'h1, 1'b1, 1'b0, 1'b0, 1};
    vecs[10] = '{1'b1, 64'h200, 4'd0, 4'd0, 64'h1, 1'b0, 1'b0, 1'b1, 1};
    vecs[11] = '{1'b0, 64'h0, 4'd0, 4'd2, 64'h10001, 1'b0, 1'b0, 1'b1, 1};
    vecs[12] = '{1'b0, 64'h0, 4'd15, 4'd15, 64'h10001, 1'b0, 1'b0, 1'b1, 0};

    reset       = 1'b1;
    new_game    = 1'b0;
    bombs_in    = '0;
    click_valid = 1'b0;
    click_x     = '0;
    click_y     = '0;
`ifdef BUSCAMINAS_FLAG_EN
    flag_valid  = 1'b0;
    flag_x      = '0;
    flag_y      = '0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk64("reset revealed", revealed, 64'h0);
    chk("reset win", int'(win), 0);
    chk("reset lose", int'(lose), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset cnt_we", int'(cnt_we), 0);

    start_game(64'h1);
    chk64("newgame revealed", revealed, 64'h0);
    chk("newgame win", int'(win), 0);
    chk("newgame lose", int'(lose), 0);
    chk("newgame click_ready", int'(click_ready), 1);

    for (int v = 0; v < 13; v++) begin
      if (vecs[v].ng) start_game(vecs[v].bombs);
      click_run(vecs[v].x, vecs[v].y, nwe, got);
      $sformat(nm, "vec%0d", v);
      chk({nm, " done_seen"}, int'(got), 1);
      chk64({nm, " revealed"}, revealed, vecs[v].exp_rev);
      chk({nm, " win"}, int'(win), int'(vecs[v].exp_win));
      chk({nm, " lose"}, int'(lose), int'(vecs[v].exp_lose));
      chk({nm, " click_ready"}, int'(click_ready), int'(vecs[v].exp_ready));
      chk({nm, " cnt_we_count"}, nwe, vecs[v].exp_nwe);
    end

    // Count values written during a full flood with a bomb in the corner.
    for (int j = 0; j < 64; j++) last_cnt[j] = 4'hF;
    start_game(64'h1);
    click_run(4'd7, 4'd7, nwe, got);
    chk("flood cnt idx1", int'(last_cnt[1]), 1);
    chk("flood cnt idx8", int'(last_cnt[8]), 1);
    chk("flood cnt idx9", int'(last_cnt[9]), 1);
    chk("flood cnt idx10", int'(last_cnt[10]), 0);
    chk("flood cnt idx63", int'(last_cnt[63]), 0);
    chk("flood cnt idx0 unwritten", int'(last_cnt[0]), 15);

    // Cycle-exact latency of a safe non-zero click.
    start_game(64'h8100_0000_0000_0081);
    @(negedge clk);
    click_valid = 1'b1;
    click_x     = 4'd1;
    click_y     = 4'd0;
    @(negedge clk);
    click_valid = 1'b0;
    chk("lat T+1 cnt_we", int'(cnt_we), 1);
    chk("lat T+1 cnt_idx", int'(cnt_idx), 1);
    chk("lat T+1 cnt_val", int'(cnt_val), 1);
    chk64("lat T+1 revealed", revealed, 64'h0);
    chk("lat T+1 done", int'(done), 0);
    @(negedge clk);
    chk64("lat T+2 revealed", revealed, 64'h2);
    chk("lat T+2 cnt_we", int'(cnt_we), 0);
    chk("lat T+2 done", int'(done), 0);
    @(negedge clk);
    chk("lat T+3 done", int'(done), 1);
    chk("lat T+3 busy", int'(busy), 1);
    @(negedge clk);
    chk("lat T+4 done", int'(done), 0);
    chk("lat T+4 busy", int'(busy), 0);
    chk("lat T+4 click_ready", int'(click_ready), 1);

    // Bomb click: lose and done one cycle later, then terminal.
    start_game(64'h1);
    @(negedge clk);
    click_valid = 1'b1;
    click_x     = 4'd0;
    click_y     = 4'd0;
    @(negedge clk);
    click_valid = 1'b0;
    chk("lose T+1 lose", int'(lose), 1);
    chk("lose T+1 done", int'(done), 1);
    chk64("lose T+1 revealed", revealed, 64'h1);
    chk("lose T+1 click_ready", int'(click_ready), 0);
    click_valid = 1'b1;
    click_x     = 4'd5;
    click_y     = 4'd5;
    repeat (3) @(negedge clk);
    chk64("lost click revealed", revealed, 64'h1);
    chk("lost click done", int'(done), 0);
    chk("lost click_ready", int'(click_ready), 0);
    chk("lost lose sticky", int'(lose), 1);
    click_valid = 1'b0;

    // new_game in the middle of a flood fill.
    start_game(64'h1);
    @(negedge clk);
    click_valid = 1'b1;
    click_x     = 4'd7;
    click_y     = 4'd7;
    @(negedge clk);
    click_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("midflood busy", int'(busy), 1);
    new_game = 1'b1;
    bombs_in = 64'h1;
    @(negedge clk);
    new_game = 1'b0;
    chk64("restart revealed", revealed, 64'h0);
    chk("restart busy", int'(busy), 0);
    chk("restart click_ready", int'(click_ready), 1);
    chk("restart done", int'(done), 0);
    chk("restart win", int'(win), 0);
    click_run(4'd7, 4'd7, nwe, got);
    chk64("restart flood revealed", revealed, ~64'h1);
    chk("restart flood win", int'(win), 1);
    chk("restart flood cnt_we_count", nwe, 63);

`ifdef BUSCAMINAS_FLAG_EN
    // Flagged cell blocks both the flood and a direct click.
    start_game(64'h1);
    @(negedge clk);
    flag_valid = 1'b1;
    flag_x     = 4'd1;
    flag_y     = 4'd1;
    @(negedge clk);
    flag_x     = 4'd9;
    flag_y     = 4'd0;
    @(negedge clk);
    flag_valid = 1'b0;
    chk64("flag set", flagged, 64'h200);
    click_run(4'd1, 4'd1, nwe, got);
    chk64("flag click ignored", revealed, 64'h0);
    click_run(4'd7, 4'd7, nwe, got);
    chk64("flag flood revealed", revealed, ~64'h201);
    chk("flag flood win", int'(win), 0);
    chk("flag flood click_ready", int'(click_ready), 1);
    @(negedge clk);
    flag_valid = 1'b1;
    flag_x     = 4'd7;
    flag_y     = 4'd7;
    @(negedge clk);
    flag_valid = 1'b0;
    chk64("flag on revealed ignored", flagged, 64'h200);
    start_game(64'h1);
    chk64("flag cleared by new_game", flagged, 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
